// File: rtl/thermal_sensor_sampler.sv
// Thermal sensor sampler: periodic four-phase req/ack handshake with an
// on-die thermal ADC, linear calibration to degrees C, EMA filtering, a
// hysteretic over-temperature alarm and a handshake-timeout fault flag.
// Optional min/max tracking is built when THERM_MINMAX_EN is defined.
module thermal_sensor_sampler #(
    parameter int ADC_W         = 12,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 255,
    parameter int EMA_SHIFT     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [ADC_W-1:0] adc_data,
    input  logic [15:0]      cal_gain_q8,
    input  logic [15:0]      cal_offset_c,
    input  logic [7:0]       alarm_hi_c,
    input  logic [7:0]       alarm_hyst_c,
    input  logic             minmax_clr,
    output logic [7:0]       temperature,
    output logic             temp_valid,
    output logic             temp_ready,
    output logic             over_temp,
    output logic             sensor_fault,
    output logic [15:0]      sample_count,
    output logic [7:0]       temp_min,
    output logic [7:0]       temp_max
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int CW = ADC_W + 17;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] ACK_LOW = 3'd2;
    localparam logic [2:0] CONV    = 3'd3;
    localparam logic [2:0] FILT    = 3'd4;

    logic [2:0]       state_q,  state_d;
    logic [PW-1:0]    period_q, period_d;
    logic [WW-1:0]    wait_q,   wait_d;
    logic [ADC_W-1:0] code_q,   code_d;
    logic [7:0]       conv_q,   conv_d;
    logic [15:0]      filt_q,   filt_d;
    logic             valid_q,  valid_d;
    logic             ready_q,  ready_d;
    logic             over_q,   over_d;
    logic             fault_q,  fault_d;
    logic [15:0]      count_q,  count_d;

    logic [CW-1:0]        prod;
    logic signed [CW-1:0] calSum;
    logic [7:0]           convClamped;
    logic signed [17:0]   diff;
    logic signed [17:0]   step;
    logic signed [17:0]   fSum;
    logic [1:0]           fsum_hi_unused;
    logic [15:0]          filtNew;
    logic [7:0]           newTemp;
    logic [7:0]           lowThr;

    // Calibrate the captured code to degrees C and clamp into the 8-bit range
    always_comb begin
        prod   = CW'(code_q) * CW'(cal_gain_q8);
        calSum = $signed(prod >> 8) + $signed({{(CW-16){cal_offset_c[15]}}, cal_offset_c});
        if (calSum[CW-1]) begin
            convClamped = 8'd0;
        end else if (|calSum[CW-2:8]) begin
            convClamped = 8'hFF;
        end else begin
            convClamped = calSum[7:0];
        end
    end

    // EMA filter step in Q8.8; the very first sample seeds the filter directly
    always_comb begin
        diff           = $signed({2'b00, conv_q, 8'h00}) - $signed({2'b00, filt_q});
        step           = diff >>> EMA_SHIFT;
        fSum           = $signed({2'b00, filt_q}) + step;
        fsum_hi_unused = fSum[17:16];
        filtNew        = ready_q ? fSum[15:0] : {conv_q, 8'h00};
        newTemp        = filtNew[15:8];
        lowThr         = (alarm_hi_c > alarm_hyst_c) ? (alarm_hi_c - alarm_hyst_c) : 8'd0;
    end

    // Handshake sequencing, timeout supervision and result bookkeeping
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        wait_d   = wait_q;
        code_d   = code_q;
        conv_d   = conv_q;
        filt_d   = filt_q;
        valid_d  = 1'b0;
        ready_d  = ready_q;
        over_d   = over_q;
        fault_d  = fault_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (!enable) begin
                    period_d = '0;
                end else if (period_q == PW'(SAMPLE_PERIOD - 1)) begin
                    if (!adc_ack) begin
                        period_d = '0;
                        state_d  = REQ;
                    end
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            REQ: begin
                if (adc_ack) begin
                    code_d  = adc_data;
                    wait_d  = '0;
                    state_d = ACK_LOW;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    fault_d = 1'b1;
                    over_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ACK_LOW: begin
                if (!adc_ack) begin
                    wait_d  = '0;
                    state_d = CONV;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    wait_d  = '0;
                    fault_d = 1'b1;
                    over_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            CONV: begin
                conv_d  = convClamped;
                state_d = FILT;
            end
            FILT: begin
                filt_d  = filtNew;
                valid_d = 1'b1;
                ready_d = 1'b1;
                count_d = count_q + 16'd1;
                fault_d = 1'b0;
                if (newTemp >= alarm_hi_c) begin
                    over_d = 1'b1;
                end else if (newTemp < lowThr) begin
                    over_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; an asynchronous reset drops the request immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            period_q <= '0;
            wait_q   <= '0;
            code_q   <= '0;
            conv_q   <= '0;
            filt_q   <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b0;
            over_q   <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            wait_q   <= wait_d;
            code_q   <= code_d;
            conv_q   <= conv_d;
            filt_q   <= filt_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            over_q   <= over_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end

`ifdef THERM_MINMAX_EN
    logic [7:0] min_q;
    logic [7:0] max_q;

    // Track extremes of published temperatures; a clear beats a coincident update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (minmax_clr) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else if (state_q == FILT) begin
            if (newTemp < min_q) min_q <= newTemp;
            if (newTemp > max_q) max_q <= newTemp;
        end
    end

    assign temp_min = min_q;
    assign temp_max = max_q;
`else
    logic minmax_clr_unused;
    assign minmax_clr_unused = minmax_clr;
    assign temp_min          = 8'hFF;
    assign temp_max          = 8'h00;
`endif

    assign adc_req      = (state_q == REQ);
    assign temperature  = filt_q[15:8];
    assign temp_valid   = valid_q;
    assign temp_ready   = ready_q;
    assign over_temp    = over_q;
    assign sensor_fault = fault_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_thermal_sensor_sampler.sv
// Directed testbench for thermal_sensor_sampler. Two instances run in
// lockstep on shared stimulus: one with EMA_SHIFT=2, one unfiltered.
// Min/max expectations follow THERM_MINMAX_EN.
module tb_thermal_sensor_sampler;

    localparam int SP = 8;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rstN;
    logic        enable;
    logic        adcAck;
    logic [11:0] adcData;
    logic [15:0] calGain;
    logic [15:0] calOffset;
    logic [7:0]  alarmHi;
    logic [7:0]  alarmHyst;
    logic        minmaxClr;

    logic        adcReq,   adcReqF;
    logic [7:0]  temp,     tempF;
    logic        valid,    validF;
    logic        ready,    readyF;
    logic        over,     overF;
    logic        fault,    faultF;
    logic [15:0] count,    countF;
    logic [7:0]  tMin,     tMinF;
    logic [7:0]  tMax,     tMaxF;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    thermal_sensor_sampler #(.ADC_W(12), .SAMPLE_PERIOD(SP), .TIMEOUT(TO), .EMA_SHIFT(2)) dut (
        .clk(clk), .reset(rstN), .enable(enable), .adc_req(adcReq), .adc_ack(adcAck),
        .adc_data(adcData), .cal_gain_q8(calGain), .cal_offset_c(calOffset),
        .alarm_hi_c(alarmHi), .alarm_hyst_c(alarmHyst), .minmax_clr(minmaxClr),
        .temperature(temp), .temp_valid(valid), .temp_ready(ready), .over_temp(over),
        .sensor_fault(fault), .sample_count(count), .temp_min(tMin), .temp_max(tMax)
    );

    thermal_sensor_sampler #(.ADC_W(12), .SAMPLE_PERIOD(SP), .TIMEOUT(TO), .EMA_SHIFT(0)) dutF (
        .clk(clk), .reset(rstN), .enable(enable), .adc_req(adcReqF), .adc_ack(adcAck),
        .adc_data(adcData), .cal_gain_q8(calGain), .cal_offset_c(calOffset),
        .alarm_hi_c(alarmHi), .alarm_hyst_c(alarmHyst), .minmax_clr(minmaxClr),
        .temperature(tempF), .temp_valid(validF), .temp_ready(readyF), .over_temp(overF),
        .sensor_fault(faultF), .sample_count(countF), .temp_min(tMinF), .temp_max(tMaxF)
    );

    // Pulse reset and leave the bench on a falling edge with enable low
    task automatic applyReset();
        enable = 1'b0;
        adcAck = 1'b0;
        minmaxClr = 1'b0;
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    // Wait for adc_req (bounded), return true if seen
    task automatic waitReq(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 4 * SP + 20; i++) begin
            @(negedge clk);
            if (adcReq) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL req_wait: adc_req=%b, required 1", adcReq);
        end
    endtask

    // Play the ADC side of one full handshake, ending on the temp_valid cycle
    task automatic applyStimulus(input logic [11:0] code);
        bit seen;
        waitReq(seen);
        if (!seen) return;
        adcData = code;
        adcAck  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!adcReq) begin
                seen = 1'b1;
                break;
            end
        end
        adcAck = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL req_drop: adc_req=%b, required 0", adcReq);
            return;
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL valid_wait: temp_valid=%b, required 1", valid);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        enable = 1'b0;
        adcAck = 1'b0;
        adcData = '0;
        minmaxClr = 1'b0;
        calGain = 16'd256;
        calOffset = 16'hFFF6;
        alarmHi = 8'd85;
        alarmHyst = 8'd5;
        #12;
        tests++; if (adcReq !== 1'b0) begin fails++; $display("[TB] FAIL rst_req: got %b, required 0", adcReq); end
        tests++; if (temp !== 8'd0) begin fails++; $display("[TB] FAIL rst_temp: got %0d, required 0", temp); end
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_valid: got %b, required 0", valid); end
        tests++; if (ready !== 1'b0) begin fails++; $display("[TB] FAIL rst_ready: got %b, required 0", ready); end
        tests++; if (over !== 1'b0) begin fails++; $display("[TB] FAIL rst_over: got %b, required 0", over); end
        tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL rst_fault: got %b, required 0", fault); end
        tests++; if (count !== 16'd0) begin fails++; $display("[TB] FAIL rst_count: got %0d, required 0", count); end
        tests++; if (tMin !== 8'hFF) begin fails++; $display("[TB] FAIL rst_min: got %0d, required 255", tMin); end
        tests++; if (tMax !== 8'h00) begin fails++; $display("[TB] FAIL rst_max: got %0d, required 0", tMax); end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        applyReset();
        calGain = 16'd256;
        calOffset = 16'hFFF6;
        enable = 1'b1;
        n = 0;
        for (int i = 1; i <= SP + 20; i++) begin
            @(negedge clk);
            if (adcReq) begin
                n = i;
                break;
            end
        end
        tests++; if (n != SP) begin fails++; $display("[TB] FAIL first_req_delay: got %0d, required %0d", n, SP); end
        applyStimulus(12'd60);
        tests++; if (temp !== 8'd50) begin fails++; $display("[TB] FAIL basic_t1: got %0d, required 50", temp); end
        tests++; if (ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready: got %b, required 1", ready); end
        tests++; if (count !== 16'd1) begin fails++; $display("[TB] FAIL basic_count: got %0d, required 1", count); end
        applyStimulus(12'd90);
        tests++; if (temp !== 8'd57) begin fails++; $display("[TB] FAIL basic_ema: got %0d, required 57", temp); end
        tests++; if (tempF !== 8'd80) begin fails++; $display("[TB] FAIL basic_noema: got %0d, required 80", tempF); end
        tests++; if (over !== 1'b0) begin fails++; $display("[TB] FAIL basic_over: got %b, required 0", over); end
        @(negedge clk);
        tests++; if (valid !== 1'b0) begin fails++; $display("[TB] FAIL valid_pulse: got %b, required 0", valid); end
    endtask

    task automatic test_clamp();
        applyReset();
        calGain = 16'd256;
        calOffset = 16'd0;
        enable = 1'b1;
        applyStimulus(12'd4095);
        tests++; if (temp !== 8'd255) begin fails++; $display("[TB] FAIL clamp_hi: got %0d, required 255", temp); end
        tests++; if (over !== 1'b1) begin fails++; $display("[TB] FAIL clamp_over: got %b, required 1", over); end
        calOffset = 16'hFFF6;
        applyStimulus(12'd0);
        tests++; if (tempF !== 8'd0) begin fails++; $display("[TB] FAIL clamp_lo: got %0d, required 0", tempF); end
        tests++; if (temp !== 8'd191) begin fails++; $display("[TB] FAIL clamp_ema: got %0d, required 191", temp); end
        tests++; if (overF !== 1'b0) begin fails++; $display("[TB] FAIL clamp_over_clr: got %b, required 0", overF); end
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        applyReset();
        calGain = 16'd256;
        calOffset = 16'hFFF6;
        enable = 1'b1;
        applyStimulus(12'd60);
        waitReq(seen);
        n = seen ? 1 : 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!adcReq) break;
            n++;
        end
        tests++; if (n != TO) begin fails++; $display("[TB] FAIL to_req_len: got %0d, required %0d", n, TO); end
        tests++; if (fault !== 1'b1) begin fails++; $display("[TB] FAIL to_fault: got %b, required 1", fault); end
        tests++; if (over !== 1'b1) begin fails++; $display("[TB] FAIL to_over: got %b, required 1", over); end
        tests++; if (temp !== 8'd50) begin fails++; $display("[TB] FAIL to_temp_hold: got %0d, required 50", temp); end
        tests++; if (count !== 16'd1) begin fails++; $display("[TB] FAIL to_count: got %0d, required 1", count); end
        applyStimulus(12'd35);
        tests++; if (fault !== 1'b0) begin fails++; $display("[TB] FAIL to_fault_clr: got %b, required 0", fault); end
        tests++; if (over !== 1'b0) begin fails++; $display("[TB] FAIL to_over_clr: got %b, required 0", over); end
        tests++; if (temp !== 8'd43) begin fails++; $display("[TB] FAIL to_recover_ema: got %0d, required 43", temp); end
        tests++; if (tempF !== 8'd25) begin fails++; $display("[TB] FAIL to_recover: got %0d, required 25", tempF); end
        tests++; if (count !== 16'd2) begin fails++; $display("[TB] FAIL to_count2: got %0d, required 2", count); end
    endtask

    task automatic test_ack_stuck();
        bit seen;
        bit reqAgain;
        waitReq(seen);
        adcData = 12'd60;
        adcAck = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!adcReq) break;
        end
        reqAgain = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (adcReq) reqAgain = 1'b1;
        end
        tests++; if (fault !== 1'b1) begin fails++; $display("[TB] FAIL ackhi_fault: got %b, required 1", fault); end
        tests++; if (reqAgain !== 1'b0) begin fails++; $display("[TB] FAIL ackhi_noreq: got %b, required 0", reqAgain); end
        tests++; if (tempF !== 8'd25) begin fails++; $display("[TB] FAIL ackhi_hold: got %0d, required 25", tempF); end
        adcAck = 1'b0;
        applyStimulus(12'd35);
        tests++; if (faultF !== 1'b0) begin fails++; $display("[TB] FAIL ackhi_clr: got %b, required 0", faultF); end
    endtask

    task automatic test_hysteresis();
        logic [11:0] codes [5];
        logic        expOver [5];
        codes = '{12'd84, 12'd85, 12'd81, 12'd80, 12'd79};
        expOver = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        applyReset();
        calGain = 16'd256;
        calOffset = 16'd0;
        alarmHi = 8'd85;
        alarmHyst = 8'd5;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(codes[i]);
            tests++;
            if (overF !== expOver[i]) begin
                fails++;
                $display("[TB] FAIL hyst_%0d: temp=%0d over_temp=%b, required %b", codes[i], tempF, overF, expOver[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        waitReq(seen);
        adcData = 12'd100;
        adcAck = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!adcReq) break;
        end
        rstN = 1'b0;
        #1;
        tests++; if (adcReq !== 1'b0) begin fails++; $display("[TB] FAIL mid_req: got %b, required 0", adcReq); end
        tests++; if (tempF !== 8'd0) begin fails++; $display("[TB] FAIL mid_temp: got %0d, required 0", tempF); end
        tests++; if (countF !== 16'd0) begin fails++; $display("[TB] FAIL mid_count: got %0d, required 0", countF); end
        tests++; if (readyF !== 1'b0) begin fails++; $display("[TB] FAIL mid_ready: got %b, required 0", readyF); end
        adcAck = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_enable_drop();
        bit seen;
        bit reqAgain;
        applyReset();
        calGain = 16'd256;
        calOffset = 16'hFFF6;
        enable = 1'b1;
        waitReq(seen);
        enable = 1'b0;
        applyStimulus(12'd60);
        tests++; if (countF !== 16'd1) begin fails++; $display("[TB] FAIL en_count: got %0d, required 1", countF); end
        tests++; if (tempF !== 8'd50) begin fails++; $display("[TB] FAIL en_temp: got %0d, required 50", tempF); end
        reqAgain = 1'b0;
        for (int i = 0; i < 3 * SP + 5; i++) begin
            @(negedge clk);
            if (adcReq) reqAgain = 1'b1;
        end
        tests++; if (reqAgain !== 1'b0) begin fails++; $display("[TB] FAIL en_park: got %b, required 0", reqAgain); end
    endtask

    task automatic test_minmax();
        logic [7:0] expMin;
        logic [7:0] expMax;
        applyReset();
        calGain = 16'd256;
        calOffset = 16'd0;
        enable = 1'b1;
        applyStimulus(12'd40);
        applyStimulus(12'd70);
        applyStimulus(12'd55);
`ifdef THERM_MINMAX_EN
        expMin = 8'd40;
        expMax = 8'd70;
`else
        expMin = 8'hFF;
        expMax = 8'h00;
`endif
        tests++; if (tMinF !== expMin) begin fails++; $display("[TB] FAIL mm_min: got %0d, required %0d", tMinF, expMin); end
        tests++; if (tMaxF !== expMax) begin fails++; $display("[TB] FAIL mm_max: got %0d, required %0d", tMaxF, expMax); end
        minmaxClr = 1'b1;
        @(negedge clk);
        minmaxClr = 1'b0;
        tests++; if (tMinF !== 8'hFF) begin fails++; $display("[TB] FAIL mm_clr_min: got %0d, required 255", tMinF); end
        tests++; if (tMaxF !== 8'h00) begin fails++; $display("[TB] FAIL mm_clr_max: got %0d, required 0", tMaxF); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_timeout();
        test_ack_stuck();
        test_hysteresis();
        test_reset_mid();
        test_enable_drop();
        test_minmax();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/thermal_sensor_sampler.md
Name: thermal_sensor_sampler

Overview:
- Producer end of the power manager's `temperature` input.
- Runs a periodic four-phase req/ack handshake with an on-die thermal ADC, calibrates the raw code to degrees C and EMA-filters it.
- Drives the 8-bit `temperature` consumed by the power manager's leakage scaling, plus a hysteretic over-temp flag and a sensor-fault flag.

Parameters:
- ADC_W, 12, raw ADC code width.
- SAMPLE_PERIOD, 1000, clk cycles between sample requests (>=2).
- TIMEOUT, 255, max cycles waited on any ack edge before declaring a fault.
- EMA_SHIFT, 2, filter weight 1/2^EMA_SHIFT (0 = no filtering).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sampling enable.
- adc_req  out  1  conversion request.
- adc_ack  in  1  ADC acknowledge; `adc_data` is valid while high.
- adc_data  in  ADC_W  raw code.
- cal_gain_q8  in  16  unsigned gain, Q8.8.
- cal_offset_c  in  16  signed offset, degrees C.
- alarm_hi_c  in  8  over-temp set threshold.
- alarm_hyst_c  in  8  hysteresis width.
- minmax_clr  in  1  clears min/max trackers (optional feature).
- temperature  out  8  filtered temperature, degrees C.
- temp_valid  out  1  one-cycle pulse on each update.
- temp_ready  out  1  sticky; first sample completed.
- over_temp  out  1  thermal alarm.
- sensor_fault  out  1  handshake timeout flag.
- sample_count  out  16  successful samples, wraps at 65535->0.
- temp_min  out  8  minimum temperature seen (optional feature).
- temp_max  out  8  maximum temperature seen (optional feature).

Behaviour:
- Reset values: adc_req=0, temperature=0, temp_valid=0, temp_ready=0, over_temp=0, sensor_fault=0, sample_count=0, temp_min=8'hFF, temp_max=0; filter state=0; FSM=IDLE; period counter=0.
- FSM states: IDLE, REQ, ACK_LOW, CONV, FILT.
- IDLE: period counter increments while enable=1 and holds at 0 while enable=0. At SAMPLE_PERIOD-1: counter->0, go to REQ. The first request is issued SAMPLE_PERIOD cycles after enable rises.
- REQ: adc_req=1. On adc_ack=1, capture adc_data, deassert adc_req next cycle, go to ACK_LOW.
- ACK_LOW: adc_req=0. Wait for adc_ack=0, then go to CONV.
- Timeout: a wait counter resets on entry to REQ and to ACK_LOW. Reaching TIMEOUT cycles in either state -> adc_req=0, sensor_fault=1, over_temp=1 (fail-safe), go to IDLE. temperature holds its last value and sample_count does not increment.
- CONV (1 cycle): conv = ((code * cal_gain_q8) >> 8) + cal_offset_c. Compute in 29-bit signed; clamp to 0..255.
- FILT (1 cycle):
  - Filter state f is 16-bit Q8.8. If temp_ready=0: f = conv<<8. Else: f = f + ((conv<<8) - f) >>> EMA_SHIFT, 18-bit signed intermediate, arithmetic shift.
  - temperature = f[15:8], truncated. temp_valid pulses this cycle.
  - temp_ready=1; sample_count+1; sensor_fault cleared.
  - Return to IDLE.
- over_temp:
  - Evaluated in FILT on the new temperature: set if temperature >= alarm_hi_c; clear if temperature < sat0(alarm_hi_c - alarm_hyst_c); otherwise hold.
  - A fault-forced over_temp clears only through this evaluation.
- enable deasserted mid-handshake: the transaction completes normally, then the FSM parks in IDLE.
- Reset asserted mid-handshake: adc_req drops asynchronously and all state returns to reset values.
- adc_ack high while in IDLE: ignored. A new request is not issued until ack is low; REQ waits for a rising level only after ACK_LOW has completed.
- Update latency: 3 cycles from adc_ack low (seen in ACK_LOW) to the temp_valid pulse.

Optional Feature:
- THERM_MINMAX_EN defined:
  - temp_min and temp_max update in FILT: min/max of the current value and the new temperature.
  - minmax_clr=1 restores 8'hFF/0. If minmax_clr coincides with FILT, the clear wins and the new sample is not recorded.
- Undefined: temp_min is tied to 8'hFF, temp_max to 0, and minmax_clr is ignored.

Test Plan:
- Basic conversion: gain=256, offset=-10, EMA_SHIFT=2, adc=60 -> first temp_valid gives temperature=50, temp_ready=1, sample_count=1. Next adc=90 -> f=14720, temperature=57.
- Clamping: adc=4095, gain=256, offset=0 -> temperature=255. Then adc=0, offset=-10 with EMA_SHIFT=0 -> temperature=0.
- Timeout: adc_ack held 0, TIMEOUT=255 -> adc_req drops after 255 cycles; sensor_fault=1, over_temp=1, temperature unchanged. The next good sample (25C, alarm_hi=85) clears both.
- Hysteresis, alarm_hi=85, hyst=5, EMA_SHIFT=0:
  - temps 84 -> over_temp=0.
  - 85 -> 1.
  - 81 -> 1.
  - 80 -> 1.
  - 79 -> 0.
- Reset and enable:
  - reset driven low while in ACK_LOW -> adc_req=0, all outputs at reset values.
  - enable dropped during REQ -> the transaction finishes and no further adc_req occurs.
- With THERM_MINMAX_EN: sample sequence 40, 70, 55 -> temp_min=40, temp_max=70. minmax_clr -> 255/0.
